// File: rtl/controlunit_pipe.sv
// Registered RV32 decode control unit: decodes a 32-bit instruction into the EX-stage
// control word one cycle later, with a multi-cycle MUL hold that stalls fetch.
module controlunit_pipe #(
  parameter int          MUL_LATENCY = 3,
  parameter bit          ENABLE_M    = 1'b1,
  parameter logic [11:0] GPIO_CSR    = 12'hF02,
  parameter logic [11:0] IN_CSR      = 12'hF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        stall_o,
  output logic        valid_EX,
  output logic [3:0]  aluop_EX,
  output logic        alusrc_EX,
  output logic [1:0]  regsel_EX,
  output logic        regwrite_EX,
  output logic        GPIO_we_EX,
  output logic        illegal_EX,
  output logic        state_o
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_WAIT = 1'b1;

  localparam int              CW       = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MULH  = 4'b0110;
  localparam logic [3:0] OP_MULHU = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;

  typedef struct packed {
    logic       valid;
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] regsel;
    logic       regwrite;
    logic       gpio_we;
    logic       illegal;
  } ctrl_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [11:0] csr;
  logic        unused_rs1;

  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign csr        = instr[31:20];
  assign unused_rs1 = ^instr[19:15];

  // Shared funct3 -> ALU op map for the funct7 0x00 R-type and the I-type group.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  ctrl_t dec;
  logic  dec_is_mul;
  logic  legal;

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec_is_mul = 1'b0;
    legal      = 1'b1;
    case (opcode)
      7'h33: begin
        dec.regsel   = 2'b10;
        dec.regwrite = 1'b1;
        case (funct7)
          7'h00: dec.aluop = base_op(funct3);
          7'h20: begin
            if (funct3 == 3'b000)      dec.aluop = OP_SUB;
            else if (funct3 == 3'b101) dec.aluop = OP_SRA;
            else                       legal = 1'b0;
          end
          7'h01: begin
            dec_is_mul = 1'b1;
            if (!ENABLE_M)             legal = 1'b0;
            else if (funct3 == 3'b000) dec.aluop = OP_MUL;
            else if (funct3 == 3'b001) dec.aluop = OP_MULH;
            else if (funct3 == 3'b011) dec.aluop = OP_MULHU;
            else                       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      7'h13: begin
        dec.alusrc   = 1'b1;
        dec.regsel   = 2'b10;
        dec.regwrite = 1'b1;
        dec.aluop    = base_op(funct3);
        // Shift-immediates encode their variant in funct7; everything else ignores it.
        if (funct3 == 3'b001 && funct7 != 7'h00) legal = 1'b0;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'h20)      dec.aluop = OP_SRA;
          else if (funct7 != 7'h00) legal = 1'b0;
        end
      end
      7'h37: begin
        dec.regsel   = 2'b01;
        dec.regwrite = 1'b1;
      end
      7'h73: begin
        if (funct3 == 3'b001 && csr == GPIO_CSR)    dec.gpio_we = 1'b1;
        else if (funct3 == 3'b001 && csr == IN_CSR) dec.regwrite = (rd != 5'd0);
        else                                        legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec_is_mul  = 1'b0;
    end
  end

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ex_q, ex_d;
  logic          accept;

  assign stall_o = (state_q == MUL_WAIT);
  assign accept  = instr_valid && !stall_o && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ex_d    = '0;
    end else if (state_q == MUL_WAIT) begin
      // EX word is held; writeback is released only on the final MUL cycle.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        ex_d.regwrite = 1'b1;
        state_d       = IDLE;
      end
    end else if (accept) begin
      ex_d = dec;
      if (dec_is_mul && MUL_LATENCY > 1) begin
        ex_d.regwrite = 1'b0;
        cnt_d         = CNT_LOAD;
        state_d       = MUL_WAIT;
      end
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign valid_EX    = ex_q.valid;
  assign aluop_EX    = ex_q.aluop;
  assign alusrc_EX   = ex_q.alusrc;
  assign regsel_EX   = ex_q.regsel;
  assign regwrite_EX = ex_q.regwrite;
  assign GPIO_we_EX  = ex_q.gpio_we;
  assign illegal_EX  = ex_q.illegal;
  assign state_o     = state_q;

endmodule

// File: tb/tb_controlunit_pipe.sv
// Directed bench for controlunit_pipe: default build, an ENABLE_M=0 build and a
// MUL_LATENCY=1 build share one stimulus stream.
module tb_controlunit_pipe;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;

  logic       stall_a, valid_a, alusrc_a, regwrite_a, gpio_a, illegal_a, state_a;
  logic [3:0] aluop_a;
  logic [1:0] regsel_a;
  logic       stall_n, valid_n, alusrc_n, regwrite_n, gpio_n, illegal_n, state_n;
  logic [3:0] aluop_n;
  logic [1:0] regsel_n;
  logic       stall_l, valid_l, alusrc_l, regwrite_l, gpio_l, illegal_l, state_l;
  logic [3:0] aluop_l;
  logic [1:0] regsel_l;

  int checks = 0;
  int errors = 0;

  controlunit_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .stall_o(stall_a), .valid_EX(valid_a), .aluop_EX(aluop_a), .alusrc_EX(alusrc_a),
    .regsel_EX(regsel_a), .regwrite_EX(regwrite_a), .GPIO_we_EX(gpio_a),
    .illegal_EX(illegal_a), .state_o(state_a)
  );

  controlunit_pipe #(.ENABLE_M(1'b0)) u_nom (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .stall_o(stall_n), .valid_EX(valid_n), .aluop_EX(aluop_n), .alusrc_EX(alusrc_n),
    .regsel_EX(regsel_n), .regwrite_EX(regwrite_n), .GPIO_we_EX(gpio_n),
    .illegal_EX(illegal_n), .state_o(state_n)
  );

  controlunit_pipe #(.MUL_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .stall_o(stall_l), .valid_EX(valid_l), .aluop_EX(aluop_l), .alusrc_EX(alusrc_l),
    .regsel_EX(regsel_l), .regwrite_EX(regwrite_l), .GPIO_we_EX(gpio_l),
    .illegal_EX(illegal_l), .state_o(state_l)
  );

  // Observed word layout: {valid, aluop, alusrc, regsel, regwrite, gpio_we, illegal, stall}
  logic [11:0] obs_a, obs_n, obs_l;
  assign obs_a = {valid_a, aluop_a, alusrc_a, regsel_a, regwrite_a, gpio_a, illegal_a, stall_a};
  assign obs_n = {valid_n, aluop_n, alusrc_n, regsel_n, regwrite_n, gpio_n, illegal_n, stall_n};
  assign obs_l = {valid_l, aluop_l, alusrc_l, regsel_l, regwrite_l, gpio_l, illegal_l, stall_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exw(input logic v, input logic [3:0] op, input logic src,
                                      input logic [1:0] sel, input logic rw, input logic gw,
                                      input logic ill, input logic st);
    return {v, op, src, sel, rw, gw, ill, st};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic f);
    instr_valid = v;
    instr       = w;
    flush       = f;
  endtask

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_SRAI  = 32'h40315093;
  localparam logic [31:0] I_MUL   = 32'h023100B3;
  localparam logic [31:0] I_GPIO  = 32'hF0229073;
  localparam logic [31:0] I_IN    = 32'hF00010F3;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;
  localparam logic [31:0] I_ADDI  = 32'h00A00093;
  localparam logic [31:0] I_SUB   = 32'h402080B3;
  localparam logic [31:0] I_BSLLI = 32'h40109093;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("reset_outputs", obs_a, 12'h000);
    chk("reset_state", {11'd0, state_a}, 12'h000);
    rst_n = 1'b1;
    tick();
    chk("idle_bubble", obs_a, 12'h000);

    drive(1'b1, I_ADD, 1'b0);
    tick();
    chk("add", obs_a, exw(1, 4'b0011, 0, 2'b10, 1, 0, 0, 0));
    drive(1'b1, I_SRAI, 1'b0);
    tick();
    chk("srai", obs_a, exw(1, 4'b1010, 1, 2'b10, 1, 0, 0, 0));

    drive(1'b1, I_MUL, 1'b0);
    tick();
    chk("mul_c1", obs_a, exw(1, 4'b0101, 0, 2'b10, 0, 0, 0, 1));
    chk("mul_c1_state", {11'd0, state_a}, 12'h001);
    chk("mul_nom_illegal", obs_n, exw(1, 4'b0000, 0, 2'b00, 0, 0, 1, 0));
    chk("mul_lat1", obs_l, exw(1, 4'b0101, 0, 2'b10, 1, 0, 0, 0));
    drive(1'b1, I_ADD, 1'b0);
    tick();
    chk("mul_c2", obs_a, exw(1, 4'b0101, 0, 2'b10, 0, 0, 0, 1));
    tick();
    chk("mul_c3", obs_a, exw(1, 4'b0101, 0, 2'b10, 1, 0, 0, 0));
    tick();
    chk("add_after_mul", obs_a, exw(1, 4'b0011, 0, 2'b10, 1, 0, 0, 0));

    drive(1'b1, I_GPIO, 1'b0);
    tick();
    chk("csr_gpio", obs_a, exw(1, 4'b0000, 0, 2'b00, 0, 1, 0, 0));
    drive(1'b1, I_IN, 1'b0);
    tick();
    chk("csr_in", obs_a, exw(1, 4'b0000, 0, 2'b00, 1, 0, 0, 0));
    drive(1'b1, I_LUI, 1'b0);
    tick();
    chk("lui", obs_a, exw(1, 4'b0000, 0, 2'b01, 1, 0, 0, 0));
    drive(1'b1, I_ADDI, 1'b0);
    tick();
    chk("addi", obs_a, exw(1, 4'b0011, 1, 2'b10, 1, 0, 0, 0));
    drive(1'b1, I_SUB, 1'b0);
    tick();
    chk("sub", obs_a, exw(1, 4'b0100, 0, 2'b10, 1, 0, 0, 0));

    drive(1'b1, I_BAD, 1'b0);
    tick();
    chk("illegal_ffff", obs_a, exw(1, 4'b0000, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b1, I_BSLLI, 1'b0);
    tick();
    chk("illegal_slli_f7", obs_a, exw(1, 4'b0000, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("illegal_one_cycle", obs_a, 12'h000);

    drive(1'b1, I_ADD, 1'b1);
    tick();
    chk("flush_drops_instr", obs_a, 12'h000);

    drive(1'b1, I_MUL, 1'b0);
    tick();
    chk("flush_mul_c1", obs_a, exw(1, 4'b0101, 0, 2'b10, 0, 0, 0, 1));
    drive(1'b1, I_ADD, 1'b1);
    tick();
    chk("flush_bubble", obs_a, 12'h000);
    chk("flush_state", {11'd0, state_a}, 12'h000);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("flush_no_regwrite", {11'd0, regwrite_a}, 12'h000);
    tick();
    chk("flush_no_regwrite2", {11'd0, regwrite_a}, 12'h000);

    drive(1'b1, I_MUL, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("rst_mul_c2", obs_a, exw(1, 4'b0101, 0, 2'b10, 0, 0, 0, 1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", obs_a, 12'h000);
    chk("async_reset_state", {11'd0, state_a}, 12'h000);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_reset_bubble", obs_a, 12'h000);
    drive(1'b1, I_ADD, 1'b0);
    tick();
    chk("post_reset_add", obs_a, exw(1, 4'b0011, 0, 2'b10, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
